// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;
    localparam int MIN_DIV = 2;
    localparam int HOLD_W  = 16;

    typedef enum logic {HOLD = 1'b0, RUN = 1'b1} seq_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: period counter, active/shadow divide values and
// registered clk_out/tick derived from the next counter state.
module clkdiv_ch
    import clkdiv_pkg::*;
#(
    parameter int               DIV_W = 16,
    parameter logic [DIV_W-1:0] DEF   = DIV_W'(2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             restart,
    input  logic             wr,
    input  logic [DIV_W-1:0] val,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);
    logic [DIV_W-1:0] cnt, act, shd;
    logic [DIV_W-1:0] cnt_nxt, act_nxt, n_eff;
    logic             pend_nxt, wrap;

    // A period boundary is the cycle after tick, or a forced restart.
    always_comb begin
        wrap     = restart | (run & tick);
        act_nxt  = (wrap && pend) ? shd : act;
        pend_nxt = wrap ? wr : (pend | wr);
        cnt_nxt  = (wrap || !run) ? '0 : cnt + DIV_W'(1);
        n_eff    = (act_nxt < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : act_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            act     <= DEF;
            shd     <= DEF;
            pend    <= 1'b0;
            clk_out <= 1'b1;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            act     <= act_nxt;
            pend    <= pend_nxt;
            if (wr) shd <= val;
            clk_out <= cnt_nxt < (n_eff - (n_eff >> 1));
            tick    <= cnt_nxt == (n_eff - DIV_W'(1));
        end
    end
endmodule

// File: rtl/clkdiv_multi.sv
// Top-level clock/reset generator: reset synchroniser, hold sequencer and
// NUM_CH programmable divider channels.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      DIV_W    = 16,
    parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV  = {16'd512, 16'd32, 16'd2},
    parameter int                      RST_HOLD = 16,
    localparam int                     SEL_W    = sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_pend,
    output logic              reset
);
    logic [1:0]        sync_q;
    logic              rst_s;
    seq_t              state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done, restart;

    assign rst_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b00;
        else      sync_q <= {sync_q[0], 1'b1};
    end

    assign hold_done = (state == HOLD) && rst_s && (hold_cnt == HOLD_W'(RST_HOLD - 1));
    // RUN entry counts as a restart so pending HOLD writes land at k=0.
    assign restart   = hold_done || ((state == RUN) && sync);

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD:    if (hold_done) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HOLD;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == HOLD && rst_s) hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign reset = (state == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_ch #(
            .DIV_W (DIV_W),
            .DEF   (DEF_DIV[i*DIV_W +: DIV_W])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .run     (state == RUN),
            .restart (restart),
            .wr      (div_wr && (div_sel == SEL_W'(i))),
            .val     (div_val),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (div_pend[i])
        );
    end
endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised successor to the fixed divide-by-2/32/512 clock/reset generator.
- Provides NUM_CH independent runtime-programmable clock dividers. Each channel has a registered divided clock and a one-cycle tick enable.
- Adds a synchronised, stretched reset output and a global phase-align pulse.
- Sits at the top of the design, directly on the 60 MHz system clock. All downstream modules take their clocks, enables and reset from it.

Parameters:
- NUM_CH, 3: number of divider channels, 1..8.
- DIV_W, 16: width of each divide value.
- DEF_DIV, {16'd512,16'd32,16'd2}: packed NUM_CH*DIV_W reset divide values; channel 0 is the LSB slice.
- RST_HOLD, 16: cycles that `reset` stays low after synchronised release, 1..2^16-1.

Ports:
- clk  in  1  system clock, 60 MHz.
- rst  in  1  asynchronous active-low reset.
- div_wr  in  1  write strobe for a channel divide value.
- div_sel  in  SEL_W=max(1,$clog2(NUM_CH))  channel index for div_wr.
- div_val  in  DIV_W  new divide value N.
- sync  in  1  phase-align pulse; restarts every channel at count 0.
- clk_out  out  NUM_CH  registered divided clocks.
- tick  out  NUM_CH  one-cycle pulse on the last cycle of each period.
- div_pend  out  NUM_CH  shadow value written but not yet applied.
- reset  out  1  active-low reset to downstream; asynchronous assert, synchronous release.

Behaviour:
- Reset input:
  - rst low asynchronously clears all state.
  - Output reset values: reset=0, clk_out=all 1, tick=0, div_pend=0.
  - Active divide values and shadow values return to DEF_DIV.
- Reset synchroniser: 2-flop, asynchronously cleared by rst. The output rst_s goes high 2 cycles after rst rises.
- Sequencer states HOLD and RUN:
  - HOLD is entered on rst. A hold counter counts while rst_s=1.
  - After RST_HOLD counted cycles, the sequencer moves to RUN.
  - `reset` goes high on the first RUN cycle, i.e. RST_HOLD+2 cycles after rst rises.
  - In HOLD, channel counters stay at 0, clk_out=1 and tick=0.
  - rst low mid-RUN returns immediately to reset values.
- Channel with active value N:
  - Effective N = max(N, 2); values 0 and 1 behave as 2.
  - k counts cycles since RUN entry or the last restart.
  - clk_out is high when (k mod N) < N-(N>>1), low otherwise. For odd N, high lasts one cycle longer than low.
  - tick is high when (k mod N) = N-1.
  - Both outputs are registered, with no combinational path from the counter to the output.
  - Example N=2: clk_out=1,0,1,0..., tick=0,1,0,1...
  - DEF_DIV reproduces the legacy /2, /32, /512 ratios.
- Programming:
  - A div_wr with div_sel<NUM_CH loads the shadow value and sets div_pend[sel] the next cycle.
  - The shadow value becomes active on the cycle after that channel's tick; k restarts at 0 and div_pend clears.
  - A div_wr on the same cycle as the channel's tick does not apply until the following period.
  - A second write while pending overwrites the shadow value; the last write wins.
  - A div_wr with div_sel>=NUM_CH is ignored.
  - A div_wr during HOLD updates the shadow value. It is applied at RUN entry and div_pend clears then.
- sync:
  - In RUN, sync=1 makes every channel's k=0 on the next cycle.
  - All pending values are applied at that point and every div_pend clears.
  - tick is not generated for a truncated period.
  - sync during HOLD is ignored.
- Simultaneous events:
  - sync and a channel's tick in the same cycle: single restart, no extra tick.
  - sync and div_wr in the same cycle: the new value becomes pending. It is not applied by that sync.

Decomposition:
- Package clkdiv_pkg:
  - MIN_DIV=2.
  - Sequencer state enum {HOLD, RUN}.
  - Function sel_w(n).
  - Hold-counter width constant (16).
- One sub-module, clkdiv_ch: one channel containing the counter, active and shadow registers, pend flag, and clk_out/tick registers.
  - Its inputs are run, restart, wr, val.
  - clkdiv_multi instantiates NUM_CH copies in a generate loop, plus the synchroniser and sequencer.

Test Plan:
- Reset release: rst 0→1 with RST_HOLD=16 → reset rises exactly 18 cycles later; clk_out=111 and tick=000 throughout HOLD.
- Defaults: after RUN entry → ch0 period 2 with tick every 2nd cycle; ch1 16 high/16 low; ch2 256 high/256 low; tick coincides with the last low cycle.
- Reprogram: write ch1 N=5 mid-period → div_pend[1]=1 until after the next ch1 tick; then clk_out=1,1,1,0,0 repeating; written values N=0/1 → period 2; div_sel=3 → ignored.
- sync: assert sync in cycle 7 of a ch2 period → all channels restart aligned next cycle with no tick for the truncated period; a pending ch0 value applies.
- Reset mid-run: pull rst low asynchronously between clock edges → outputs reach reset values immediately; shadow/active values return to DEF_DIV.
- Overlap: div_wr on the same cycle as the target tick → applied one period later; two writes back-to-back → the last write is applied.
